// File: rtl/delay_pkg.sv
// Shared types and helpers for the runtime-programmable delay line.
package delay_pkg;

    typedef enum logic {FILL, RUN} delay_state_e;

    // Returns {clamped value, overflow flag}.
    function automatic logic [32:0] clamp_delay(input int unsigned req,
                                                input int unsigned max_delay);
        if (req > max_delay) begin
            return {max_delay, 1'b1};
        end
        return {req, 1'b0};
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, old data on collision.
module sdp_ram #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 64,
    parameter              STYLE = "mlab",
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    (* ramstyle = STYLE *) logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/delay_var.sv
// Runtime-programmable delay line over a circular RAM buffer; delay counted in
// clock cycles or in valid samples. Output is masked until the line is primed.
module delay_var
    import delay_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MAX_DELAY   = 64,
    parameter int unsigned COUNT_VALID = 0,
    parameter              STYLE       = "mlab",
    parameter int unsigned DW          = $clog2(MAX_DELAY + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DW-1:0]    i_delay,
    input  logic             i_delay_load,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_din_valid,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_dout_valid,
    output logic             o_primed,
    output logic             o_delay_err
);

    localparam int unsigned   AW       = $clog2(MAX_DELAY);
    localparam int unsigned   LW       = WIDTH + 1;
    localparam logic [DW:0]   MAX_EXT  = (DW + 1)'(MAX_DELAY);
    localparam logic [AW-1:0] PTR_LAST = AW'(MAX_DELAY - 1);

    delay_state_e     r_state, w_state_d;
    logic [DW-1:0]    r_delay, w_delay_d;
    logic [DW-1:0]    r_fill, w_fill_d;
    logic [AW-1:0]    r_wr_ptr, w_wr_ptr_d, w_raddr;
    logic             r_err, w_err_d;
    logic [LW-1:0]    r_last, w_rdata, w_line;
    logic [WIDTH-1:0] r_hold;
    logic             w_step;
    logic [32:0]      w_clamp;
    logic [DW:0]      w_rsum;

    assign w_step  = (COUNT_VALID != 0) ? i_din_valid : 1'b1;
    assign w_clamp = clamp_delay(32'(i_delay), MAX_DELAY);

    always_comb begin
        w_wr_ptr_d = r_wr_ptr;
        if (w_step) begin
            w_wr_ptr_d = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
        end
        // Read ahead against next cycle's pointer so the registered read lands on time.
        w_rsum = (DW + 1)'(w_wr_ptr_d) + MAX_EXT - {1'b0, r_delay};
        if (w_rsum >= MAX_EXT) begin
            w_rsum = w_rsum - MAX_EXT;
        end
        w_raddr = AW'(w_rsum);
    end

    always_comb begin
        w_delay_d = r_delay;
        w_fill_d  = r_fill;
        w_state_d = r_state;
        w_err_d   = r_err;
        if (i_delay_load) begin
            w_delay_d = DW'(w_clamp[32:1]);
            w_fill_d  = DW'(w_step);
            w_err_d   = r_err | w_clamp[0];
            w_state_d = (w_fill_d >= w_delay_d) ? RUN : FILL;
        end else if (r_state == FILL) begin
            w_fill_d  = r_fill + DW'(w_step);
            w_state_d = (w_fill_d >= r_delay) ? RUN : FILL;
        end
    end

    // A one-step delay would collide with the word being written, so bypass the RAM.
    assign w_line = (r_delay == DW'(1)) ? r_last : w_rdata;

    always_comb begin
        o_dout       = '0;
        o_dout_valid = 1'b0;
        if (r_state == RUN) begin
            if (r_delay == '0) begin
                o_dout       = i_din;
                o_dout_valid = i_din_valid;
            end else if (COUNT_VALID != 0) begin
                o_dout       = w_step ? w_line[WIDTH-1:0] : r_hold;
                o_dout_valid = i_din_valid;
            end else begin
                o_dout       = w_line[WIDTH-1:0];
                o_dout_valid = w_line[WIDTH];
            end
        end
    end

    assign o_primed    = (r_state == RUN);
    assign o_delay_err = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= FILL;
            r_delay  <= '0;
            r_fill   <= '0;
            r_wr_ptr <= '0;
            r_err    <= 1'b0;
            r_last   <= '0;
            r_hold   <= '0;
        end else begin
            r_state  <= w_state_d;
            r_delay  <= w_delay_d;
            r_fill   <= w_fill_d;
            r_wr_ptr <= w_wr_ptr_d;
            r_err    <= w_err_d;
            r_hold   <= o_dout;
            if (w_step) begin
                r_last <= {i_din_valid, i_din};
            end
        end
    end

    sdp_ram #(
        .WIDTH (LW),
        .DEPTH (MAX_DELAY),
        .STYLE (STYLE),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_step),
        .i_waddr (r_wr_ptr),
        .i_wdata ({i_din_valid, i_din}),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_delay_var.sv
// Directed bench: a cycle-counting and a valid-counting instance against hand vectors
// and a small lag model.
module tb_delay_var;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [6:0]  c_delay = '0, v_delay = '0;
    logic        c_load = 1'b0, v_load = 1'b0;
    logic [31:0] c_din = '0, v_din = '0;
    logic        c_dv = 1'b0, v_dv = 1'b0;
    logic [31:0] c_dout, v_dout;
    logic        c_dvo, c_primed, c_err, v_dvo, v_primed, v_err;

    delay_var #(.WIDTH(32), .MAX_DELAY(64), .COUNT_VALID(0)) u_dut_cyc (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_delay      (c_delay),
        .i_delay_load (c_load),
        .i_din        (c_din),
        .i_din_valid  (c_dv),
        .o_dout       (c_dout),
        .o_dout_valid (c_dvo),
        .o_primed     (c_primed),
        .o_delay_err  (c_err)
    );

    delay_var #(.WIDTH(32), .MAX_DELAY(64), .COUNT_VALID(1)) u_dut_val (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_delay      (v_delay),
        .i_delay_load (v_load),
        .i_din        (v_din),
        .i_din_valid  (v_dv),
        .o_dout       (v_dout),
        .o_dout_valid (v_dvo),
        .o_primed     (v_primed),
        .o_delay_err  (v_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Cycle-mode lag model: last load cycle, its clamped delay, sticky error.
    int          t = 0;
    int          m_l = 0;
    int          m_d = 0;
    logic        m_err = 1'b0;
    logic [32:0] hist [0:1023];
    logic [31:0] s = 32'd1;

    task automatic cyc_drive(input logic ld, input int dly, input logic [31:0] d, input logic v);
        logic [32:0] e;
        logic        ep;
        c_load  = ld;
        c_delay = 7'(dly);
        c_din   = d;
        c_dv    = v;
        #2;
        ep = (t > m_l) && (t - m_l >= m_d);
        if (!ep) e = '0;
        else if (m_d == 0) e = {v, d};
        else e = hist[t - m_d];
        check($sformatf("cyc%0d dout", t), c_dout, e[31:0]);
        check($sformatf("cyc%0d dout_valid", t), 32'(c_dvo), 32'(e[32]));
        check($sformatf("cyc%0d primed", t), 32'(c_primed), 32'(ep));
        check($sformatf("cyc%0d delay_err", t), 32'(c_err), 32'(m_err));
        hist[t] = {v, d};
        if (ld) begin
            m_l = t;
            m_d = (dly > 64) ? 64 : dly;
            m_err = m_err | (dly > 64);
        end
    endtask

    task automatic cyc_end();
        @(posedge clk);
        #1;
        t++;
    endtask

    // Valid-mode vectors, D=3, valid on alternate cycles.
    int vt_ld [12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int vt_dv [12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    int vt_di [12] = '{0, 10, 99, 11, 99, 12, 99, 13, 99, 14, 99, 15};
    int vt_ed [12] = '{0, 0, 0, 0, 0, 0, 0, 10, 10, 11, 11, 12};
    int vt_ev [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1};
    int vt_ep [12] = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("rst cyc dout", c_dout, 32'd0);
        check("rst cyc dout_valid", 32'(c_dvo), 32'd0);
        check("rst cyc primed", 32'(c_primed), 32'd0);
        check("rst cyc delay_err", 32'(c_err), 32'd0);
        check("rst val dout", v_dout, 32'd0);
        check("rst val primed", 32'(v_primed), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (2) begin
            cyc_drive(1'b0, 0, 32'd0, 1'b0);
            cyc_end();
        end

        for (int i = 0; i < 12; i++) begin
            v_load  = vt_ld[i][0];
            v_delay = 7'd3;
            v_dv    = vt_dv[i][0];
            v_din   = 32'(vt_di[i]);
            cyc_drive(1'b0, 0, 32'd0, 1'b0);
            check($sformatf("val row%0d dout", i), v_dout, 32'(vt_ed[i]));
            check($sformatf("val row%0d dout_valid", i), 32'(v_dvo), 32'(vt_ev[i]));
            check($sformatf("val row%0d primed", i), 32'(v_primed), 32'(vt_ep[i]));
            cyc_end();
        end
        v_load = 1'b0;
        v_dv   = 1'b0;

        for (int i = 0; i < 12; i++) begin
            cyc_drive(i == 0, 5, s, 1'b1);
            s++;
            cyc_end();
        end
        for (int i = 0; i < 200; i++) begin
            cyc_drive(i == 0, 70, s, (i % 7) != 3);
            s++;
            cyc_end();
        end
        for (int i = 0; i < 10; i++) begin
            cyc_drive(i == 0, 4, s, 1'b1);
            s++;
            cyc_end();
        end
        for (int i = 0; i < 8; i++) begin
            cyc_drive(i == 0, 2, s, (i % 3) != 1);
            s++;
            cyc_end();
        end
        for (int i = 0; i < 6; i++) begin
            cyc_drive(i == 0, 2, s, 1'b1);
            s++;
            cyc_end();
        end
        for (int i = 0; i < 6; i++) begin
            cyc_drive(i == 0, 1, s, (i % 2) == 0);
            s++;
            cyc_end();
        end
        for (int i = 0; i < 20; i++) begin
            cyc_drive(i == 0, 0, $urandom, 1'($urandom_range(0, 1)));
            cyc_end();
        end

        cyc_drive(1'b0, 0, 32'hA5A5_0001, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst dout", c_dout, 32'd0);
        check("midrst dout_valid", 32'(c_dvo), 32'd0);
        check("midrst primed", 32'(c_primed), 32'd0);
        check("midrst delay_err", 32'(c_err), 32'd0);
        #1 rst_n = 1'b1;
        m_l   = t;
        m_d   = 0;
        m_err = 1'b0;
        cyc_end();
        for (int i = 0; i < 6; i++) begin
            cyc_drive(1'b0, 0, $urandom, 1'($urandom_range(0, 1)));
            cyc_end();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
